player_input_writer: RTL

Bus initiator that turns the four player buttons into memory writes. It synchronizes and debounces each button, then captures the 4-bit answer code for that player. It writes the code into the player value words (addresses 32–35) and then updates the flag word that the processor polls. It sits beside the processor on the data-memory port: it requests the port, waits for a grant, and drives `memwrite`/`adr`/`writedata` into `exmem`.

---
 rtl/player_input_writer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/player_input_writer.sv
// Turns four debounced player buttons into value and flag-word writes on a shared memory port.
// Define PLAYER_LOCKOUT_EN to ignore a player's presses while that player's flag is set.
module player_input_writer #(
    parameter int unsigned              WIDTH         = 16,
    parameter int unsigned              RAM_ADDR_BITS = 16,
    parameter logic [RAM_ADDR_BITS-1:0] P_BASE        = 16'd32,
    parameter logic [RAM_ADDR_BITS-1:0] FLAG_ADDR     = 16'd36,
    parameter int unsigned              DB_CYCLES     = 500000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               btn,
    input  logic [15:0]              code,
    input  logic                     flag_clr,
    input  logic                     grant,
    output logic                     req,
    output logic                     memwrite,
    output logic [RAM_ADDR_BITS-1:0] adr,
    output logic [WIDTH-1:0]         writedata,
    output logic                     busy,
    output logic [3:0]               flags
);

    typedef enum logic [1:0] {S_IDLE, S_WR_VAL, S_WR_FLAG} state_t;

    localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

    logic [3:0]  r_btn_meta, r_btn_sync;
    logic [15:0] r_code_meta, r_code_sync;
    logic [3:0]  w_deb, r_deb_d, w_rise, w_cap;
    logic [3:0]  w_pcode [4];

    state_t                   r_state, w_state_next;
    logic [1:0]               r_sel, w_sel_next, r_rr, w_rr_next, w_pick;
    logic [3:0]               r_val, w_val_next, r_pend, w_pend_next, r_flags, w_flags_next;
    logic                     r_req, w_req_next, r_busy, w_busy_next;
    logic [RAM_ADDR_BITS-1:0] r_adr, w_adr_next;
    logic [WIDTH-1:0]         r_wdata, w_wdata_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta  <= '0;
            r_btn_sync  <= '0;
            r_code_meta <= '0;
            r_code_sync <= '0;
            r_deb_d     <= '0;
        end else begin
            r_btn_meta  <= btn;
            r_btn_sync  <= r_btn_meta;
            r_code_meta <= code;
            r_code_sync <= r_code_meta;
            r_deb_d     <= w_deb;
        end
    end

    assign w_rise = w_deb & ~r_deb_d;
`ifdef PLAYER_LOCKOUT_EN
    assign w_cap = w_rise & ~r_flags;
`else
    assign w_cap = w_rise;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_player
            logic [19:0] r_cnt;
            logic        r_lvl;
            logic [3:0]  r_pcode;

            // The counter only runs while the synced level disagrees with the accepted one.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_btn_sync[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_lvl <= r_btn_sync[gi];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst)
                    r_pcode <= '0;
                else if (w_cap[gi])
                    r_pcode <= r_code_sync[4*gi +: 4];
            end

            assign w_deb[gi]   = r_lvl;
            assign w_pcode[gi] = r_pcode;
        end
    endgenerate

    // Round-robin: first pending player at or above rr, wrapping modulo 4.
    always_comb begin
        w_pick = r_rr;
        for (int k = 3; k >= 0; k--) begin
            if (r_pend[r_rr + 2'(k)])
                w_pick = r_rr + 2'(k);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_val_next   = r_val;
        w_rr_next    = r_rr;
        w_pend_next  = r_pend;
        w_flags_next = flag_clr ? 4'd0 : r_flags;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_sel_next          = w_pick;
                    w_val_next          = w_pcode[w_pick];
                    w_pend_next[w_pick] = 1'b0;
                    w_state_next        = S_WR_VAL;
                end
            end
            S_WR_VAL: begin
                if (grant) begin
                    w_flags_next[r_sel] = 1'b1;
                    w_rr_next           = r_sel + 2'd1;
                    w_state_next        = S_WR_FLAG;
                end
            end
            S_WR_FLAG: begin
                if (grant)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_pend_next = w_pend_next | w_cap;

        w_req_next   = 1'b0;
        w_adr_next   = '0;
        w_wdata_next = '0;
        case (w_state_next)
            S_WR_VAL: begin
                w_req_next   = 1'b1;
                w_adr_next   = P_BASE + RAM_ADDR_BITS'(w_sel_next);
                w_wdata_next = WIDTH'(w_val_next);
            end
            S_WR_FLAG: begin
                w_req_next   = 1'b1;
                w_adr_next   = FLAG_ADDR;
                // Flag data is frozen on entry so a stalled write never changes under the bus.
                w_wdata_next = (r_state == S_WR_FLAG) ? r_wdata : WIDTH'(w_flags_next);
            end
            default: ;
        endcase
        w_busy_next = (w_state_next != S_IDLE) || (|w_pend_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_val   <= '0;
            r_rr    <= '0;
            r_pend  <= '0;
            r_flags <= '0;
            r_req   <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_val   <= w_val_next;
            r_rr    <= w_rr_next;
            r_pend  <= w_pend_next;
            r_flags <= w_flags_next;
            r_req   <= w_req_next;
            r_adr   <= w_adr_next;
            r_wdata <= w_wdata_next;
            r_busy  <= w_busy_next;
        end
    end

    assign req       = r_req;
    assign memwrite  = r_req;
    assign adr       = r_adr;
    assign writedata = r_wdata;
    assign busy      = r_busy;
    assign flags     = r_flags;

endmodule
